// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter and sequencer sharing one single-port synchronous
// memory between NUM_REQ requesters.
//
// Handshake: a request is consumed on a cycle where req_valid[i] && req_ready[i].
// Requesters hold valid and payload until ready. req_ready is raised only in
// IDLE, combinationally, for the round-robin winner. Responses are a
// single-cycle rsp_valid pulse with no back-pressure. rsp_rdata carries the read
// data, or zero for a write acknowledge.
module mem_rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int AW      = 4,
    parameter int DW      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ-1:0]    req_we,
    input  logic [NUM_REQ*AW-1:0] req_addr,
    input  logic [NUM_REQ*DW-1:0] req_wdata,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic [NUM_REQ-1:0]    rsp_valid,
    output logic [DW-1:0]         rsp_rdata,
    output logic                  busy,
    output logic                  mem_rst_n,
    output logic                  mem_wr_enable,
    output logic [AW-1:0]         mem_addr,
    output logic [DW-1:0]         mem_data_in,
    input  logic [DW-1:0]         mem_data_out
);

    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state;
    logic [GW-1:0]   last_grant;
    logic [GW-1:0]   g_q;
    logic            we_q;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   wdata_q;

    logic            grant_found;
    logic [GW-1:0]   grant_idx;

    // Round-robin search: start just after last_grant, wrap, first set bit wins.
    always_comb begin
        int cand;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = int'(last_grant) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = GW'(cand);
            end
        end
    end

    // Transaction FSM: accept in IDLE, drive the memory in ISSUE, respond in DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= GW'(NUM_REQ - 1);
            g_q        <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        we_q       <= req_we[grant_idx];
                        addr_q     <= req_addr[int'(grant_idx)*AW +: AW];
                        wdata_q    <= req_wdata[int'(grant_idx)*DW +: DW];
                        g_q        <= grant_idx;
                        last_grant <= grant_idx;
                        state      <= ISSUE;
                    end
                end
                ISSUE:   state <= DONE;
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Output decode from the registered state; everything is quiet while rst is high.
    always_comb begin
        req_ready     = '0;
        rsp_valid     = '0;
        rsp_rdata     = '0;
        busy          = 1'b0;
        mem_wr_enable = 1'b0;
        if (!rst) begin
            busy = (state != IDLE);
            if (state == IDLE && grant_found) begin
                req_ready = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_idx;
            end
            if (state == ISSUE) begin
                mem_wr_enable = we_q;
            end
            if (state == DONE) begin
                rsp_valid = {{(NUM_REQ-1){1'b0}}, 1'b1} << g_q;
                rsp_rdata = we_q ? '0 : mem_data_out;
            end
        end
    end

    assign mem_rst_n   = ~rst;
    assign mem_addr    = addr_q;
    assign mem_data_in = wdata_q;

endmodule
